// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 selector (direct or round-robin) with valid/ready handshake.
// Latency: 1 cycle from in_valid&in_ready to out_valid. Backpressure: in_ready drops while full and !out_ready.
module mux_n_to_1_reg #(
  parameter int WIDTH = 6,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr;
  logic [N-1:0]       grant;
  logic [SEL_W-1:0]   gnt_idx;
  logic [SEL_W-1:0]   scan_idx;
  logic               found;
  logic               sel_oob;
  logic               load;
  logic               xfer;
  logic [WIDTH-1:0]   ch_dat [N];

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign ch_dat[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Out-of-range sel only exists when N is not a power of two.
  if ((1 << SEL_W) > N) begin : g_oob
    assign sel_oob = (int'(sel) >= N);
  end else begin : g_no_oob
    assign sel_oob = 1'b0;
  end

  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (!mode) begin
      if (!sel_oob) begin
        grant[sel] = in_valid[sel];
        gnt_idx    = sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_idx = SEL_W'((int'(rr_ptr) + k) % N);
        if (!found && in_valid[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          gnt_idx         = scan_idx;
        end
      end
    end
  end

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;
  assign in_ready  = grant & {N{load && !rst}};
  assign xfer      = |in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (out_ready) state_nxt = xfer ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= SEL_W'(N-1);
      sel_err  <= 1'b0;
    end else begin
      sel_err <= !mode && sel_oob;
      if (xfer) begin
        out_data <= ch_dat[gnt_idx];
        out_ch   <= gnt_idx;
        // rr_ptr survives DIRECT mode so round-robin resumes fairly.
        if (mode) rr_ptr <= gnt_idx;
      end
    end
  end

endmodule
